// File: rtl/hexdisplay_capture.sv
// hexdisplay_capture: receive-side decoder for a multiplexed four-digit
// seven-segment bus. Synchronizes the segment/digit-select pair, waits for
// each digit to settle, decodes the glyph to a nibble and publishes the
// reassembled 16-bit value atomically once all four digits have been seen.
// Optional feature: define HEXCAP_ORDER_CHECK_EN to require stored digits to
// follow the driver scan order 0,1,2,3 (cyclic).
module hexdisplay_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  segment,
    input  logic [3:0]  omask,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic        valid,
    output logic        update,
    output logic        error
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HELD} state_t;

    // Glyph decode: {legal, blank, nibble}
    function automatic logic [5:0] decode_glyph(input logic [6:0] seg);
        case (seg)
            7'h3F: decode_glyph = {2'b10, 4'h0};
            7'h06: decode_glyph = {2'b10, 4'h1};
            7'h5B: decode_glyph = {2'b10, 4'h2};
            7'h4F: decode_glyph = {2'b10, 4'h3};
            7'h66: decode_glyph = {2'b10, 4'h4};
            7'h6D: decode_glyph = {2'b10, 4'h5};
            7'h7D: decode_glyph = {2'b10, 4'h6};
            7'h07: decode_glyph = {2'b10, 4'h7};
            7'h7F: decode_glyph = {2'b10, 4'h8};
            7'h6F: decode_glyph = {2'b10, 4'h9};
            7'h77: decode_glyph = {2'b10, 4'hA};
            7'h7C: decode_glyph = {2'b10, 4'hB};
            7'h39: decode_glyph = {2'b10, 4'hC};
            7'h5E: decode_glyph = {2'b10, 4'hD};
            7'h79: decode_glyph = {2'b10, 4'hE};
            7'h71: decode_glyph = {2'b10, 4'hF};
            7'h00: decode_glyph = {2'b11, 4'h0};
            default: decode_glyph = 6'b00_0000;
        endcase
    endfunction

    // Digit select decode: {exactly_one_zero, index}
    function automatic logic [2:0] mask_index(input logic [3:0] m);
        case (m)
            4'b1110: mask_index = 3'b100;
            4'b1101: mask_index = 3'b101;
            4'b1011: mask_index = 3'b110;
            4'b0111: mask_index = 3'b111;
            default: mask_index = 3'b000;
        endcase
    endfunction

    logic [6:0]       r_seg_s1, r_seg_s2, r_seg_prev;
    logic [3:0]       r_mask_s1, r_mask_s2, r_mask_prev;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_stage_nib;
    logic [3:0]       r_stage_blank;
    logic [3:0]       r_seen;
    logic [15:0]      r_value;
    logic [3:0]       r_blank;
    logic             r_valid, r_update, r_error;
`ifdef HEXCAP_ORDER_CHECK_EN
    logic [1:0]       r_last;
    logic             r_have_last;
`endif

    logic             w_changed, w_eval, w_store, w_err, w_order_bad;
    logic [5:0]       w_dec;
    logic [2:0]       w_midx;
    logic [1:0]       w_digit;
    logic [3:0]       w_seen_next;

    assign w_changed = {r_mask_s2, r_seg_s2} != {r_mask_prev, r_seg_prev};
    assign w_eval    = (r_state == S_SETTLE) && !w_changed && (r_cnt == CNT_LAST);
    assign w_dec     = decode_glyph(r_seg_s2);
    assign w_midx    = mask_index(r_mask_s2);
    assign w_digit   = w_midx[1:0];

    // Two-flop synchronizer plus the previous-sample register used for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1    <= 7'h00;
            r_seg_s2    <= 7'h00;
            r_seg_prev  <= 7'h00;
            r_mask_s1   <= 4'b1111;
            r_mask_s2   <= 4'b1111;
            r_mask_prev <= 4'b1111;
        end else begin
            r_seg_s1    <= segment;
            r_seg_s2    <= r_seg_s1;
            r_seg_prev  <= r_seg_s2;
            r_mask_s1   <= omask;
            r_mask_s2   <= r_mask_s1;
            r_mask_prev <= r_mask_s2;
        end
    end

    // Settle FSM: count identical samples, evaluate once per stable sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_changed) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (w_changed) begin
                        r_cnt <= CNT_W'(1);
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_HELD;
                        r_cnt   <= CNT_MAX;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HELD: begin
                    if (w_changed) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Classify an evaluated sample: ignore idle, reject bad masks/glyphs, else store
    always_comb begin
        w_store     = 1'b0;
        w_err       = 1'b0;
        w_order_bad = 1'b0;
        if (w_eval && (r_mask_s2 != 4'b1111)) begin
            if (!w_midx[2] || !w_dec[5]) begin
                w_err = 1'b1;
            end else begin
                w_store = 1'b1;
`ifdef HEXCAP_ORDER_CHECK_EN
                // Out-of-order digit restarts the frame with itself as first digit
                if (r_have_last && (w_digit != r_last + 2'd1)) begin
                    w_err       = 1'b1;
                    w_order_bad = 1'b1;
                end
`endif
            end
        end
        w_seen_next = ((&r_seen) || w_order_bad) ? 4'b0000 : r_seen;
        if (w_store) begin
            w_seen_next = w_seen_next | (4'b0001 << w_digit);
        end
    end

    // Staging, seen tracking and atomic publish of a completed frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_nib   <= 16'h0000;
            r_stage_blank <= 4'b0000;
            r_seen        <= 4'b0000;
            r_value       <= 16'h0000;
            r_blank       <= 4'b0000;
            r_valid       <= 1'b0;
            r_update      <= 1'b0;
            r_error       <= 1'b0;
`ifdef HEXCAP_ORDER_CHECK_EN
            r_last        <= 2'd0;
            r_have_last   <= 1'b0;
`endif
        end else begin
            r_error  <= w_err;
            r_update <= &r_seen;
            r_seen   <= w_seen_next;
            if (w_store) begin
                r_stage_nib[{w_digit, 2'b00} +: 4] <= w_dec[3:0];
                r_stage_blank[w_digit]             <= w_dec[4];
            end
            if (&r_seen) begin
                r_value <= r_stage_nib;
                r_blank <= r_stage_blank;
                r_valid <= 1'b1;
            end
`ifdef HEXCAP_ORDER_CHECK_EN
            if (w_store) begin
                r_last      <= w_digit;
                r_have_last <= 1'b1;
            end else if (&r_seen) begin
                r_have_last <= 1'b0;
            end
`endif
        end
    end

    assign value  = r_value;
    assign blank  = r_blank;
    assign valid  = r_valid;
    assign update = r_update;
    assign error  = r_error;

endmodule

// File: tb/tb_hexdisplay_capture.sv
// Directed testbench for hexdisplay_capture (STABLE_CYCLES = 4).
module tb_hexdisplay_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  segment;
    logic [3:0]  omask;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        valid, update, error;

    int checks = 0;
    int errors = 0;
    int n_upd  = 0;
    int n_err  = 0;
    int n_both = 0;

    hexdisplay_capture #(.STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .segment (segment),
        .omask   (omask),
        .value   (value),
        .blank   (blank),
        .valid   (valid),
        .update  (update),
        .error   (error)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge
    always @(negedge clk) begin
        if (update) n_upd++;
        if (error) n_err++;
        if (update && error) n_both++;
    end

    task automatic drive(input int d, input logic [6:0] seg, input int cyc);
        omask   = ~(4'b0001 << d);
        segment = seg;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic idle(input int cyc);
        omask   = 4'b1111;
        segment = 7'h00;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        omask   = 4'b1111;
        segment = 7'h00;
        repeat (3) @(negedge clk);
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h expected 0000", value); end
        checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL reset_blank: got %b expected 0000", blank); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL reset_update: got %b expected 0", update); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scan();
        int bu, be;
        bu = n_upd; be = n_err;
        drive(0, 7'h71, 8);
        drive(1, 7'h5B, 8);
        drive(2, 7'h77, 8);
        drive(3, 7'h06, 6);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL scan_early_update: got %b expected 0", update); end
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL scan_atomic_value: got %h expected 0000", value); end
        @(negedge clk);
        checks++; if (update !== 1'b1) begin errors++; $display("FAIL scan_update_latency: got %b expected 1", update); end
        checks++; if (value !== 16'h1A2F) begin errors++; $display("FAIL scan_value: got %h expected 1a2f", value); end
        @(negedge clk);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL scan_update_width: got %b expected 0", update); end
        idle(10);
        checks++; if (n_upd - bu !== 1) begin errors++; $display("FAIL scan_update_count: got %0d expected 1", n_upd - bu); end
        checks++; if (n_err - be !== 0) begin errors++; $display("FAIL scan_error_count: got %0d expected 0", n_err - be); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL scan_valid: got %b expected 1", valid); end
        checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL scan_blank: got %b expected 0000", blank); end
    endtask

    task automatic test_glitch();
        int bu, be;
        do_reset();
        bu = n_upd; be = n_err;
        drive(0, 7'h71, 8);
        drive(1, 7'h5B, 8);
        drive(2, 7'h77, 4);
        segment = 7'h7E;
        repeat (2) @(negedge clk);
        segment = 7'h77;
        repeat (2) @(negedge clk);
        drive(3, 7'h06, 8);
        idle(10);
        checks++; if (value !== 16'h1A2F) begin errors++; $display("FAIL glitch_value: got %h expected 1a2f", value); end
        checks++; if (n_upd - bu !== 1) begin errors++; $display("FAIL glitch_update_count: got %0d expected 1", n_upd - bu); end
        checks++; if (n_err - be !== 0) begin errors++; $display("FAIL glitch_error_count: got %0d expected 0", n_err - be); end
    endtask

    task automatic test_blank();
        int bu;
        do_reset();
        bu = n_upd;
        drive(0, 7'h06, 8);
        drive(1, 7'h5B, 8);
        drive(2, 7'h00, 8);
        drive(3, 7'h66, 8);
        idle(10);
        checks++; if (value !== 16'h4021) begin errors++; $display("FAIL blank_value: got %h expected 4021", value); end
        checks++; if (blank !== 4'b0100) begin errors++; $display("FAIL blank_flags: got %b expected 0100", blank); end
        checks++; if (n_upd - bu !== 1) begin errors++; $display("FAIL blank_update_count: got %0d expected 1", n_upd - bu); end
    endtask

    task automatic test_errors();
        int bu, be;
        bu = n_upd; be = n_err;
        omask   = 4'b1100;
        segment = 7'h06;
        repeat (8) @(negedge clk);
        idle(8);
        checks++; if (n_err - be !== 1) begin errors++; $display("FAIL multi_select_error_count: got %0d expected 1", n_err - be); end
        checks++; if (value !== 16'h4021) begin errors++; $display("FAIL multi_select_value: got %h expected 4021", value); end
        be = n_err;
        drive(2, 7'h5B, 8);
        drive(3, 7'h66, 8);
        drive(0, 7'h06, 8);
        drive(1, 7'h7E, 8);
        checks++; if (n_err - be !== 1) begin errors++; $display("FAIL bad_glyph_error_count: got %0d expected 1", n_err - be); end
        checks++; if (n_upd - bu !== 0) begin errors++; $display("FAIL bad_glyph_no_update: got %0d expected 0", n_upd - bu); end
        drive(1, 7'h4F, 8);
        idle(8);
        checks++; if (n_upd - bu !== 1) begin errors++; $display("FAIL good_digit1_update: got %0d expected 1", n_upd - bu); end
        checks++; if (value !== 16'h4231) begin errors++; $display("FAIL good_digit1_value: got %h expected 4231", value); end
        checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL good_digit1_blank: got %b expected 0000", blank); end
        checks++; if (n_both !== 0) begin errors++; $display("FAIL update_error_overlap: got %0d expected 0", n_both); end
    endtask

    task automatic test_order();
        int bu, be, exp_err;
        do_reset();
        bu = n_upd; be = n_err;
`ifdef HEXCAP_ORDER_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        drive(0, 7'h06, 8);
        drive(2, 7'h5B, 8);
        drive(3, 7'h66, 8);
        drive(0, 7'h7F, 8);
        drive(1, 7'h4F, 8);
        drive(2, 7'h5B, 8);
        checks++; if (n_err - be !== exp_err) begin errors++; $display("FAIL order_error_count: got %0d expected %0d", n_err - be, exp_err); end
        checks++; if (n_upd - bu !== 1) begin errors++; $display("FAIL order_update_count: got %0d expected 1", n_upd - bu); end
        checks++; if (value !== 16'h4238) begin errors++; $display("FAIL order_value: got %h expected 4238", value); end
    endtask

    task automatic test_reset_midframe();
        int bu;
        drive(3, 7'h66, 8);
        drive(0, 7'h06, 8);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL midframe_pre_valid: got %b expected 1", valid); end
        #2;
        rst_n = 1'b0;
        #2;
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL async_reset_value: got %h expected 0000", value); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", valid); end
        checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL async_reset_blank: got %b expected 0000", blank); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bu = n_upd;
        drive(1, 7'h4F, 10);
        idle(8);
        checks++; if (n_upd - bu !== 0) begin errors++; $display("FAIL post_reset_no_update: got %0d expected 0", n_upd - bu); end
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL post_reset_value: got %h expected 0000", value); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", valid); end
    endtask

    initial begin
        rst_n   = 1'b0;
        omask   = 4'b1111;
        segment = 7'h00;
        test_reset();
        test_scan();
        test_glitch();
        test_blank();
        test_errors();
        test_order();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
